// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers and a sequencing FSM.
// MULT/MULTU/DIV/DIVU take 33 busy cycles; MTHI/MTLO write in one cycle from IDLE.
module mdu_ctrl #(
    parameter int unsigned ITER     = 32,
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      acc_q;     // upper: partial product / remainder, lower: multiplier / quotient
    logic [31:0]      opb_q;     // multiplicand or divisor magnitude
    logic [31:0]      src1_q;    // original dividend, returned on divide by zero
    logic             is_div_q;
    logic             sgn1_q;
    logic             sgn2_q;
    logic             div0_q;

    logic        accept;
    logic        mthi_we;
    logic        mtlo_we;
    logic        fin;
    logic        last_iter;

    logic        op_signed;
    logic        in_sgn1;
    logic        in_sgn2;
    logic [31:0] in_abs1;
    logic [31:0] in_abs2;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [63:0] acc_step;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        fin       = 1'b0;
        last_iter = (cnt_q == CNT_W'(ITER - 1));
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        accept  = 1'b1;
                        state_d = S_CALC;
                    end else if (op == OP_MTHI) begin
                        mthi_we = 1'b1;
                    end else if (op == OP_MTLO) begin
                        mtlo_we = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (last_iter) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                fin     = !cancel;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand magnitudes; only MULT and DIV (op[0]==0) treat inputs as signed
    always_comb begin
        op_signed = !op[0];
        in_sgn1   = op_signed && src1[31];
        in_sgn2   = op_signed && src2[31];
        in_abs1   = in_sgn1 ? (~src1 + 32'd1) : src1;
        in_abs2   = in_sgn2 ? (~src2 + 32'd1) : src2;
    end

    // One shift-add or restoring-divide step
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_rem   = div_ge ? (div_shift - {1'b0, opb_q}) : div_shift;
        if (is_div_q) begin
            acc_step = {div_rem[31:0], acc_q[30:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[31:1]};
        end
    end

    // Sign fix-up and divide-by-zero override applied in FIN
    always_comb begin
        prod_fix = (sgn1_q ^ sgn2_q) ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = (sgn1_q ^ sgn2_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = sgn1_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (is_div_q) begin
            if (div0_q) begin
                res_hi = src1_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // Datapath, HI/LO and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= HILO_RST;
            lo       <= HILO_RST;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            src1_q   <= '0;
            is_div_q <= 1'b0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= fin;
            if (accept) begin
                cnt_q    <= '0;
                acc_q    <= {32'd0, in_abs1};
                opb_q    <= in_abs2;
                src1_q   <= src1;
                is_div_q <= op[1];
                sgn1_q   <= in_sgn1;
                sgn2_q   <= in_sgn2;
                div0_q   <= op[1] && (src2 == 32'd0);
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_step;
            end
            if (mthi_we) begin
                hi <= src1;
            end
            if (mtlo_we) begin
                lo <= src1;
            end
            if (fin) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver queues timed expected events, a
// negedge monitor retires them and checks busy/done/hi/lo every cycle.
module tb_mdu_ctrl;

    localparam logic [31:0] HILO_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.ITER(32), .HILO_RST(HILO_RST)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef enum {EV_MD, EV_MTHI, EV_MTLO, EV_RST} ev_kind_t;
    typedef struct {
        int unsigned cyc;
        ev_kind_t    kind;
        logic [31:0] hi;
        logic [31:0] lo;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] exp_hi = HILO_RST;
    logic [31:0] exp_lo = HILO_RST;

    // Architectural result {HI, LO} computed with plain 64-bit arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin
                p = sa * sb;
                return p;
            end
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic exp_done;
        logic exp_busy;
        ev_t  ev;
        if (chk_en) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                ev = evq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d actual=none expected=event@%0d", cyc, ev.cyc);
            end
            exp_done = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                case (ev.kind)
                    EV_MD: begin
                        exp_hi   = ev.hi;
                        exp_lo   = ev.lo;
                        exp_done = 1'b1;
                    end
                    EV_MTHI: exp_hi = ev.hi;
                    EV_MTLO: exp_lo = ev.lo;
                    default: begin
                        exp_hi = HILO_RST;
                        exp_lo = HILO_RST;
                    end
                endcase
            end
            exp_busy = 1'b0;
            foreach (evq[i]) if (evq[i].kind == EV_MD) exp_busy = 1'b1;
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("hi", hi, exp_hi);
            check("lo", lo, exp_lo);
        end
    end

    // Drive one cycle of inputs and record the expected consequence
    task automatic drive(input logic r, input logic s, input logic c, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit use_exp, input logic [63:0] expv);
        bit          md_busy;
        logic [63:0] res;
        reset  = r;
        start  = s;
        cancel = c;
        op     = o;
        src1   = a;
        src2   = b;
        md_busy = 1'b0;
        foreach (evq[i]) if (evq[i].kind == EV_MD) md_busy = 1'b1;
        if (r) begin
            evq.delete();
            evq.push_back('{cyc + 1, EV_RST, HILO_RST, HILO_RST});
        end else if (md_busy) begin
            if (c) evq.delete();
        end else if (s && !c) begin
            if (o < 3'd4) begin
                res = use_exp ? expv : ref_md(o, a, b);
                evq.push_back('{cyc + 34, EV_MD, res[63:32], res[31:0]});
            end else if (o == 3'd4) begin
                evq.push_back('{cyc + 1, EV_MTHI, a, 32'd0});
            end else if (o == 3'd5) begin
                evq.push_back('{cyc + 1, EV_MTLO, 32'd0, a});
            end
        end
        @(negedge clk);
        #1;
        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0, 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
        drive(1'b0, 1'b1, 1'b0, o, a, b, 1'b1, expv);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 50));
            5: return 32'd0 - 32'($urandom_range(1, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd7;
        src1   = 32'd0;
        src2   = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Multiply and divide sign/boundary cases with literal expectations
        issue(3'd0, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1); idle(35);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001); idle(35);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD); idle(35);
        issue(3'd3, 32'd100,       32'd7,         64'h0000_0002_0000_000E); idle(35);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000); idle(35);
        issue(3'd3, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF); idle(35);

        // Reset ten cycles into a divide, then a clean multiply
        issue(3'd2, 32'd1000, 32'd3, ref_md(3'd2, 32'd1000, 32'd3));
        idle(9);
        drive(1'b1, 1'b0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0, 64'd0);
        idle(2);
        issue(3'd0, 32'h0001_0003, 32'hFFFF_0002, ref_md(3'd0, 32'h0001_0003, 32'hFFFF_0002));
        idle(35);

        // Cancel mid-multiply together with an MTHI, then MTHI from IDLE
        issue(3'd0, 32'd77, 32'd99, ref_md(3'd0, 32'd77, 32'd99));
        idle(18);
        drive(1'b0, 1'b1, 1'b1, 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0, 64'd0);
        idle(3);
        drive(1'b0, 1'b1, 1'b0, 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0, 64'd0);
        idle(2);

        // Back-to-back: ignored start while busy, next op issued in the done cycle
        issue(3'd0, 32'hDEAD_BEEF, 32'h0000_1234, ref_md(3'd0, 32'hDEAD_BEEF, 32'h0000_1234));
        idle(10);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 32'd55, 32'd5, 1'b0, 64'd0);
        idle(22);
        issue(3'd3, 32'hFFFF_0000, 32'd13, ref_md(3'd3, 32'hFFFF_0000, 32'd13));
        idle(36);

        // Randomized traffic, including starts while busy, cancels and resets
        for (int n = 0; n < 1500; n++) begin
            drive(1'b0 || ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0),
                  3'($urandom_range(0, 7)),
                  pick(), pick(), 1'b0, 64'd0);
        end
        idle(40);

        check("queue_drained", 32'(evq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit with its sequencing controller and HI/LO architectural registers. It executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle. It sits beside the single-cycle integer ALU in EX and raises busy so the pipeline stalls until the result lands in HI/LO. MFHI/MFLO read the hi/lo outputs directly.

Parameters:
ITER, 32, iteration cycles in CALC state (fixed at 32; the datapath is 32-bit)
HILO_RST, 32'h0000_0000, reset value of HI and LO

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
src1  in  32  rs operand (multiplicand/dividend; data for MTHI/MTLO)
src2  in  32  rt operand (multiplier/divisor)
cancel  in  1  exception/flush abort
busy  out  1  high while state is CALC or FIN
done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE, busy=0, done=0, hi=lo=HILO_RST. Iteration counter and working registers cleared.
- States: IDLE, CALC, FIN.
- IDLE, start=1, cancel=0, op 0-3 at edge t: latch |src1|, |src2| (signed ops) or raw (unsigned ops), sign bits, op. Counter=0. Go to CALC; busy=1 from t.
- IDLE, start=1, op=4 (5): hi (lo) <= src1 at the same edge. No busy, no done. State stays IDLE.
- IDLE, op 6/7, or start with cancel=1: no effect.
- CALC: one step per cycle for ITER cycles.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - After the ITER-th cycle (edge t+32), go to FIN.
- FIN (one cycle): apply sign fix. At edge t+33: write hi/lo, done=1 for the following cycle, busy=0, state IDLE.
- Latency: busy is high for exactly 33 cycles. New HI/LO is visible in the same cycle done is high.
- start in CALC/FIN: ignored (no queue). The pipeline must hold via busy.
- start in the cycle done is high: accepted normally (state is IDLE).
- Sign rules:
  - Product negated when s1^s2.
  - Quotient negated when s1^s2.
  - Remainder takes the sign of src1.
  - All results are mod 2^32 per half.
- 0x8000_0000 DIV 0xFFFF_FFFF: LO=0x8000_0000, HI=0. No trap.
- Divide by zero (src2==0, DIV or DIVU): same 33-cycle latency, then HI=src1 (original), LO=32'hFFFF_FFFF. No flag.
- cancel=1 in CALC or FIN: at the next edge go to IDLE, busy=0. No HI/LO write, no done. Cancel wins over FIN completion in the same cycle.
- cancel=1 in IDLE: also blocks that cycle's MTHI/MTLO.
- Operands are latched at start; src1/src2 may change during CALC without effect.
- The overflow/trap logic in EX is independent of this block. mdu_ctrl never raises exceptions.

Test Plan:
- Reset mid-CALC (10 cycles after a DIV start) -> next cycle busy=0, done=0, hi=lo=0. A subsequent MULT starts cleanly.
- MULT src1=0xFFFF_FFFD (-3), src2=5 -> busy high 33 cycles, then done pulse with hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV -7/2 (0xFFFF_FFF9, 2) -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100/7 -> lo=0x0000_000E, hi=0x0000_0002. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIVU 0x1234_5678/0 -> after 33 cycles hi=0x1234_5678, lo=0xFFFF_FFFF.
- MULT started; cancel at cycle 20; MTHI 0xA5A5_A5A5 issued in the same cycle -> no done pulse, HI/LO unchanged, MTHI ignored. MTHI reissued in IDLE -> hi=0xA5A5_A5A5 next cycle, lo unchanged, busy stays 0.
- Back-to-back: DIVU issued in the done cycle of a MULT; start asserted during busy -> MULT result written, DIVU accepted immediately, the mid-busy start is ignored (exactly two done pulses).
